// File: rtl/overture_ctrl_if.sv
// Bus bundle between the Overture sequencer and its environment:
// instruction fetch port, ALU operand/result lanes, and the byte I/O ports.
interface overture_ctrl_if;
    // Instruction fetch
    logic [7:0] pc;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;

    // ALU lanes (the ALU itself is purely combinational)
    logic [7:0] alu_cmd;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [7:0] alu_result;

    // Input byte port
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    // Output byte port
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    // Sequencer side
    modport master (
        output pc, instr_ready, alu_cmd, alu_in1, alu_in2, in_ready, out_valid, out_data,
        input  instr_valid, instr, alu_result, in_valid, in_data, out_ready
    );

    // Environment side: program memory, ALU and byte endpoints
    modport slave (
        input  pc, instr_ready, alu_cmd, alu_in1, alu_in2, in_ready, out_valid, out_data,
        output instr_valid, instr, alu_result, in_valid, in_data, out_ready
    );
endinterface

// File: rtl/overture_ctrl.sv
// Overture instruction sequencer: fetches 8-bit instructions, decodes them into
// immediates, ALU calculations, register/port copies and conditional jumps,
// and owns the six general registers r0..r5.
module overture_ctrl #(
    parameter logic [31:0] UUID = 32'd0,
    parameter string       NAME = ""
) (
    input  logic           clk,
    input  logic           rst,
    overture_ctrl_if.master bus
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_IMM  = 2'b00,
        OP_CALC = 2'b01,
        OP_COPY = 2'b10,
        OP_COND = 2'b11
    } op_t;

    // COPY operand codes that address something other than a register
    localparam logic [2:0] SRC_IN   = 3'd6;  // read the input port
    localparam logic [2:0] DST_OUT  = 3'd7;  // write the output port
    localparam logic [2:0] NUM_REGS = 3'd6;  // codes below this are r0..r5

    // Anonymous instances (no identity given) are marked in the elaborated hierarchy.
    if (UUID == 32'd0 && NAME == "") begin : g_anonymous
    end

    state_t     state;
    state_t     state_next;
    logic [7:0] regs [6];
    logic [7:0] ir;
    logic [7:0] pc_q;
    logic       out_valid_q;
    logic [7:0] out_data_q;

    // Decode results
    op_t        op;
    logic [2:0] src;
    logic [2:0] dst;
    logic       slot_free;
    logic       src_ok;
    logic       dst_ok;
    logic       done;
    logic       load_out;
    logic       jump_taken;
    logic       cond_true;
    logic       r3_zero;
    logic       r3_neg;
    logic [7:0] copy_val;

    assign op  = op_t'(ir[7:6]);
    assign src = ir[5:3];
    assign dst = ir[2:0];

    // Decode the held instruction: operand readiness, completion, copy value and branch test.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        slot_free  = 1'b0;
        src_ok     = 1'b0;
        dst_ok     = 1'b0;
        done       = 1'b0;
        load_out   = 1'b0;
        jump_taken = 1'b0;
        cond_true  = 1'b0;
        r3_zero    = 1'b0;
        r3_neg     = 1'b0;
        copy_val   = 8'h00;

        // The output slot can take a byte if empty or being drained this cycle.
        slot_free = !out_valid_q || bus.out_ready;
        src_ok    = (src != SRC_IN)  || bus.in_valid;
        dst_ok    = (dst != DST_OUT) || slot_free;

        case (src)
            3'd0:    copy_val = regs[0];
            3'd1:    copy_val = regs[1];
            3'd2:    copy_val = regs[2];
            3'd3:    copy_val = regs[3];
            3'd4:    copy_val = regs[4];
            3'd5:    copy_val = regs[5];
            3'd6:    copy_val = bus.in_data;
            default: copy_val = 8'h00;
        endcase

        // r3 is tested as a signed byte.
        r3_zero = (regs[3] == 8'h00);
        r3_neg  = regs[3][7];
        case (ir[2:0])
            3'd0:    cond_true = 1'b0;
            3'd1:    cond_true = r3_zero;
            3'd2:    cond_true = r3_neg;
            3'd3:    cond_true = r3_neg || r3_zero;
            3'd4:    cond_true = 1'b1;
            3'd5:    cond_true = !r3_zero;
            3'd6:    cond_true = !r3_neg;
            default: cond_true = !r3_neg && !r3_zero;
        endcase

        // Only COPY can stall; everything else finishes in its single EXEC cycle.
        done       = (state == EXEC) && ((op != OP_COPY) || (src_ok && dst_ok));
        load_out   = done && (op == OP_COPY) && (dst == DST_OUT);
        jump_taken = (op == OP_COND) && cond_true;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: fetch until a word arrives, execute until the instruction completes.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (bus.instr_valid) state_next = EXEC;
            EXEC:    if (done)            state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // FSM outputs: fetch handshake and input-port consumption strobe.
    always_comb begin
        bus.instr_ready = (state == FETCH);
        // Only asserted when the copy can complete on the output side as well,
        // so an offered input byte is never taken without being delivered.
        bus.in_ready    = (state == EXEC) && (op == OP_COPY) && (src == SRC_IN) && dst_ok;
    end

    // Datapath: instruction register, program counter, register file and output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir          <= 8'h00;
            pc_q        <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            // NOTE: the register file is six flops wide, not a RAM, so it is reset like any other state.
            for (int i = 0; i < 6; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (state == FETCH && bus.instr_valid) begin
                ir <= bus.instr;
            end

            if (done) begin
                pc_q <= jump_taken ? regs[0] : pc_q + 8'd1;
                case (op)
                    OP_IMM:  regs[0] <= {2'b00, ir[5:0]};
                    OP_CALC: regs[3] <= bus.alu_result;
                    OP_COPY: if (dst < NUM_REGS) regs[dst] <= copy_val;
                    default: ;
                endcase
            end

            // A new byte takes priority over draining, keeping out_valid high back to back.
            if (load_out) begin
                out_valid_q <= 1'b1;
                out_data_q  <= copy_val;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.alu_cmd   = {5'b00000, ir[2:0]};
    assign bus.alu_in1   = regs[1];
    assign bus.alu_in2   = regs[2];

endmodule
